// File: rtl/fb_bkg_row_sequencer_if.sv
// Sequencer bus: row-counter handshake, background ROM read port and frame-buffer write port.
// master = the sequencer; slave = the row counter / ROM / frame-buffer side.
interface fb_bkg_row_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              row_en;
  logic              row_done;
  logic              px_valid;
  logic [8:0]        px_x;
  logic [ADDR_W-1:0] bkg_rom_addr;
  logic [DATA_W-1:0] bkg_rom_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_din;

  modport master (
    output row_en, bkg_rom_addr, fb_we, fb_addr, fb_din,
    input  row_done, px_valid, px_x, bkg_rom_data
  );

  modport slave (
    input  row_en, bkg_rom_addr, fb_we, fb_addr, fb_din,
    output row_done, px_valid, px_x, bkg_rom_data
  );
endinterface

// File: rtl/fb_bkg_row_sequencer.sv
// Background-pass frame sequencer: walks every row through the row counter and writes ROM pixels to the frame buffer.
// Macro FB_BKG_SOLID_COLOR_EN bypasses the ROM and fills the frame with bkg_color instead.
module fb_bkg_row_sequencer #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [DATA_W-1:0]      bkg_color,
  output logic                   busy,
  output logic                   done,
  fb_bkg_row_sequencer_if.master bus
);
  localparam int Y_W = $clog2(V_LINES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_NEXT, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              drain_q, drain_d;
  logic              row_en;
  logic              done_c;

  logic              vld_p1_q, vld_p1_d;
  logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;
`ifdef FB_BKG_SOLID_COLOR_EN
  logic [DATA_W-1:0] color_p2_q, color_p2_d;
  logic              unused_rom;
`else
  logic              unused_color;
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    base_d  = base_q;
    drain_d = drain_q;
    row_en  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        y_d    = '0;
        base_d = '0;
        if (start) state_d = S_ROW;
      end
      S_ROW: begin
        row_en = 1'b1;
        if (bus.row_done) state_d = S_NEXT;
      end
      // One idle cycle lets the row counter park before the next row.
      S_NEXT: begin
        y_d     = y_q + Y_W'(1);
        base_d  = base_q + ADDR_W'(H_PIXELS);
        drain_d = 1'b0;
        state_d = (y_q == Y_W'(V_LINES - 1)) ? S_DRAIN : S_ROW;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // p1: ROM address issue
    vld_p1_d  = bus.px_valid && busy;
    addr_p1_d = vld_p1_d ? (base_q + ADDR_W'(bus.px_x)) : addr_p1_q;
    // p2: frame-buffer write, aligned with the ROM's one-cycle read latency
    vld_p2_d  = vld_p1_q;
    addr_p2_d = addr_p1_q;
`ifdef FB_BKG_SOLID_COLOR_EN
    color_p2_d = vld_p1_q ? bkg_color : color_p2_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      base_q    <= '0;
      drain_q   <= 1'b0;
      vld_p1_q  <= 1'b0;
      addr_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
`ifdef FB_BKG_SOLID_COLOR_EN
      color_p2_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      base_q    <= base_d;
      drain_q   <= drain_d;
      vld_p1_q  <= vld_p1_d;
      addr_p1_q <= addr_p1_d;
      vld_p2_q  <= vld_p2_d;
      addr_p2_q <= addr_p2_d;
`ifdef FB_BKG_SOLID_COLOR_EN
      color_p2_q <= color_p2_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_c;
  assign bus.row_en  = row_en;
  assign bus.fb_we   = vld_p2_q;
  assign bus.fb_addr = addr_p2_q;
`ifdef FB_BKG_SOLID_COLOR_EN
  assign bus.bkg_rom_addr = '0;
  assign bus.fb_din       = color_p2_q;
  assign unused_rom       = ^bus.bkg_rom_data;
`else
  assign bus.bkg_rom_addr = addr_p1_q;
  assign bus.fb_din       = vld_p2_q ? bus.bkg_rom_data : '0;
  assign unused_color     = ^bkg_color;
`endif
endmodule

// File: tb/tb_fb_bkg_row_sequencer.sv
// Directed bench for fb_bkg_row_sequencer: a 4x3 instance for detailed checks and a default 320x240 instance for full-frame counts.
module tb_fb_bkg_row_sequencer;
  localparam int SH = 4;
  localparam int SV = 3;
  localparam int DH = 320;
  localparam int DV = 240;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam logic [DW-1:0] FILL = 12'h0F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_s, start_s, busy_s, done_s;
  logic          rst_n_d, start_d, busy_d, done_d;
  logic [DW-1:0] color;

  int n_chk  = 0;
  int n_fail = 0;

  fb_bkg_row_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();
  fb_bkg_row_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();

  fb_bkg_row_sequencer #(.H_PIXELS(SH), .V_LINES(SV), .ADDR_W(AW), .DATA_W(DW)) dut_s (
    .clk(clk), .reset_n(rst_n_s), .start(start_s), .bkg_color(color),
    .busy(busy_s), .done(done_s), .bus(s_if.master)
  );

  fb_bkg_row_sequencer #(.H_PIXELS(DH), .V_LINES(DV), .ADDR_W(AW), .DATA_W(DW)) dut_d (
    .clk(clk), .reset_n(rst_n_d), .start(start_d), .bkg_color(color),
    .busy(busy_d), .done(done_d), .bus(d_if.master)
  );

  // Behavioural row counters: x=0 one cycle after row_en, idle whenever row_en is low.
  logic       s_act, d_act;
  logic [8:0] s_x, d_x;
  always @(posedge clk) begin
    if (!rst_n_s || !s_if.row_en) begin s_act <= 1'b0; s_x <= '0; end
    else if (!s_act)              begin s_act <= 1'b1; s_x <= '0; end
    else if (s_x == 9'(SH-1))     begin s_act <= 1'b0; s_x <= '0; end
    else                          s_x <= s_x + 9'd1;
  end
  always @(posedge clk) begin
    if (!rst_n_d || !d_if.row_en) begin d_act <= 1'b0; d_x <= '0; end
    else if (!d_act)              begin d_act <= 1'b1; d_x <= '0; end
    else if (d_x == 9'(DH-1))     begin d_act <= 1'b0; d_x <= '0; end
    else                          d_x <= d_x + 9'd1;
  end
  assign s_if.px_valid = s_act;
  assign s_if.px_x     = s_x;
  assign s_if.row_done = s_act && (s_x == 9'(SH-1));
  assign d_if.px_valid = d_act;
  assign d_if.px_x     = d_x;
  assign d_if.row_done = d_act && (d_x == 9'(DH-1));

  // ROM models with one-cycle read latency.
  logic [DW-1:0] s_rom, d_rom;
  always @(posedge clk) s_rom <= s_if.bkg_rom_addr[DW-1:0] ^ 12'hA5A;
  always @(posedge clk) d_rom <= d_if.bkg_rom_addr[DW-1:0] ^ 12'hA5A;
  assign s_if.bkg_rom_data = s_rom;
  assign d_if.bkg_rom_data = d_rom;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_din(input logic [AW-1:0] a);
`ifdef FB_BKG_SOLID_COLOR_EN
    return FILL;
`else
    return a[DW-1:0] ^ 12'hA5A;
`endif
  endfunction

  int            s_wr, s_done, s_rows;
  logic [AW-1:0] s_exp_addr;
  logic          s_h1, s_h2;

  task automatic s_step();
    @(negedge clk);
    chk_eq("s_we_latency", s_if.fb_we, s_h2);
    if (s_if.fb_we) begin
      chk_eq("s_addr", s_if.fb_addr, s_exp_addr);
      chk_eq("s_din", s_if.fb_din, exp_din(s_if.fb_addr));
`ifdef FB_BKG_SOLID_COLOR_EN
      chk_eq("s_rom_addr_zero", s_if.bkg_rom_addr, 0);
`endif
      s_exp_addr++;
      s_wr++;
    end
    if (done_s) s_done++;
    if (s_if.row_done) s_rows++;
    s_h2 = s_h1;
    s_h1 = s_if.px_valid && busy_s;
  endtask

  task automatic s_clear();
    s_wr = 0; s_done = 0; s_rows = 0; s_exp_addr = '0; s_h1 = 1'b0; s_h2 = 1'b0;
  endtask

  // Cycle count is inclusive: the start cycle and the done cycle both count.
  task automatic s_frame();
    int cyc;
    s_clear();
    cyc = 1;
    start_s = 1'b1;
    do begin
      s_step();
      start_s = 1'b0;
      cyc++;
    end while (!done_s && cyc < 200);
    chk_eq("s_done_cycle", cyc, 1 + SV*(SH+2) + 2 + 1);
    chk_eq("s_busy_at_done", busy_s, 1);
    s_step();
    chk_eq("s_busy_fall", busy_s, 0);
    repeat (3) s_step();
    chk_eq("s_write_count", s_wr, SH*SV);
    chk_eq("s_done_count", s_done, 1);
  endtask

  initial begin
    int cyc, d_wr, d_done, guard, s_we_after, s_done_after;
    logic [AW-1:0] d_exp, d_last;
    color = FILL;
    rst_n_s = 1'b0; rst_n_d = 1'b0; start_s = 1'b1; start_d = 1'b1;
    s_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_row_en", s_if.row_en, 0);
    chk_eq("rst_busy", busy_s, 0);
    chk_eq("rst_done", done_s, 0);
    chk_eq("rst_fb_we", s_if.fb_we, 0);
    chk_eq("rst_rom_addr", s_if.bkg_rom_addr, 0);
    chk_eq("rst_fb_addr", s_if.fb_addr, 0);
    chk_eq("rst_fb_din", s_if.fb_din, 0);
    chk_eq("rst_d_busy", busy_d, 0);
    chk_eq("rst_d_fb_we", d_if.fb_we, 0);

    start_s = 1'b0; start_d = 1'b0; rst_n_s = 1'b1; rst_n_d = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("idle_busy", busy_s, 0);
    chk_eq("idle_row_en", s_if.row_en, 0);

    s_frame();

    // Reset during row 1 at x=2, then restart from address 0.
    s_clear();
    start_s = 1'b1;
    s_step();
    start_s = 1'b0;
    guard = 0;
    while (!(s_rows == 1 && s_if.px_valid && s_if.px_x == 9'd2) && guard < 60) begin
      s_step();
      guard++;
    end
    chk_eq("midrow_reached", guard < 60, 1);
    rst_n_s = 1'b0;
    @(negedge clk);
    chk_eq("midrow_row_en", s_if.row_en, 0);
    chk_eq("midrow_fb_we", s_if.fb_we, 0);
    chk_eq("midrow_done", done_s, 0);
    chk_eq("midrow_busy", busy_s, 0);
    rst_n_s = 1'b1;
    s_we_after = 0; s_done_after = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_if.fb_we) s_we_after++;
      if (done_s) s_done_after++;
    end
    chk_eq("midrow_no_writes", s_we_after, 0);
    chk_eq("midrow_no_done", s_done_after, 0);
    s_frame();

    // Full default frame with a second start pulse mid-frame.
    d_wr = 0; d_done = 0; d_exp = '0; d_last = '0;
    cyc = 1;
    start_d = 1'b1;
    do begin
      @(negedge clk);
      start_d = (cyc == 1000);
      cyc++;
      if (d_if.fb_we) begin
        chk_eq("d_addr", d_if.fb_addr, d_exp);
        chk_eq("d_din", d_if.fb_din, exp_din(d_exp));
        d_last = d_if.fb_addr;
        d_exp++;
        d_wr++;
      end
    end while (!done_d && cyc < 80000);
    start_d = 1'b0;
    chk_eq("d_done_cycle", cyc, 77284);
    chk_eq("d_write_count", d_wr, 76800);
    chk_eq("d_last_addr", d_last, 76799);
    chk_eq("d_busy_at_done", busy_d, 1);
    @(negedge clk);
    chk_eq("d_busy_fall", busy_d, 0);
    repeat (4) begin
      @(negedge clk);
      if (done_d) d_done++;
      if (d_if.fb_we) d_wr++;
    end
    chk_eq("d_single_done", d_done, 0);
    chk_eq("d_no_late_writes", d_wr, 76800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
